// File: rtl/circuit_pkg.sv
// -----------------------------------------------------------------------------
// circuit_pkg
// Shared definitions for the circuit1 result path: default result widths,
// the packed result record, and the reset values of the running x bounds.
// -----------------------------------------------------------------------------
package circuit_pkg;

    localparam int ZW = 8;
    localparam int XW = 16;

    typedef struct packed {
        logic signed [ZW-1:0] z;
        logic signed [XW-1:0] x;
    } result_t;

    // x_min starts at the most positive value and x_max at the most negative,
    // so the first accepted sample always replaces both.
    localparam logic signed [XW-1:0] X_MIN_INIT = {1'b0, {(XW-1){1'b1}}};
    localparam logic signed [XW-1:0] X_MAX_INIT = {1'b1, {(XW-1){1'b0}}};

endpackage

// File: rtl/result_capture_fifo_if.sv
// -----------------------------------------------------------------------------
// result_capture_fifo_if
// Capture and drain handshake of the result capture FIFO.
//   cap_en, z, x           : capture request and the sampled results
//   out_valid, out_ready   : drain handshake
//   out_z, out_x           : head entry (show-ahead)
// master = producer/consumer side, slave = the FIFO.
// -----------------------------------------------------------------------------
interface result_capture_fifo_if #(
    parameter int ZW = circuit_pkg::ZW,
    parameter int XW = circuit_pkg::XW
);
    logic                 cap_en;
    logic signed [ZW-1:0] z;
    logic signed [XW-1:0] x;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [ZW-1:0] out_z;
    logic signed [XW-1:0] out_x;

    modport master (
        output cap_en, z, x, out_ready,
        input  out_valid, out_z, out_x
    );

    modport slave (
        input  cap_en, z, x, out_ready,
        output out_valid, out_z, out_x
    );
endinterface

// File: rtl/result_capture_fifo_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with show-ahead read data and registered status.
//   clk, rst   : clock, synchronous active-high reset (also clears storage)
//   push_i     : write wdata_i this cycle (caller guarantees room)
//   pop_i      : advance the read pointer (caller guarantees not empty)
//   rdata_o    : entry at the read pointer
//   count_o    : occupancy 0..DEPTH
//   full_o     : count == DEPTH
//   empty_o    : count == 0
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 24,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wrPtr_q;
    logic [PW-1:0] rdPtr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          full_q;
    logic          empty_q;

    // A simultaneous push and pop leaves occupancy unchanged.
    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + CW'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CW'(1);
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wrPtr_q] <= wdata_i;
                wrPtr_q        <= wrPtr_q + PW'(1);
            end
            if (pop_i) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign rdata_o = mem_q[rdPtr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/result_capture_fifo.sv
// -----------------------------------------------------------------------------
// result_capture_fifo
// Captures circuit1 results (z, x) on flagged cycles into a FIFO that drains
// through a valid/ready port. Also tracks running min/max of accepted x and a
// sticky overflow flag for captures dropped while full.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : capture and drain handshake (slave side)
//   count     : occupancy 0..DEPTH
//   full      : count == DEPTH
//   empty     : count == 0
//   overflow  : sticky, a capture was dropped
//   x_max     : largest accepted x since reset
//   x_min     : smallest accepted x since reset
// -----------------------------------------------------------------------------
module result_capture_fifo
    import circuit_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int ZW    = circuit_pkg::ZW,
    parameter int XW    = circuit_pkg::XW
) (
    input  logic                       clk,
    input  logic                       rst,
    result_capture_fifo_if.slave       bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic signed [XW-1:0]       x_max,
    output logic signed [XW-1:0]       x_min
);
    localparam int W = ZW + XW;
    localparam logic signed [XW-1:0] X_MAX_RST = {1'b1, {(XW-1){1'b0}}};
    localparam logic signed [XW-1:0] X_MIN_RST = {1'b0, {(XW-1){1'b1}}};

    logic                 pop;
    logic                 push;
    logic                 drop;
    logic [W-1:0]         headData;
    logic                 overflow_q;
    logic signed [XW-1:0] xMax_q;
    logic signed [XW-1:0] xMin_q;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // capture when the consumer is draining.
    assign pop  = ~empty & bus.out_ready;
    assign push = bus.cap_en & (~full | pop);
    assign drop = bus.cap_en & full & ~pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({bus.z, bus.x}),
        .rdata_o (headData),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    // Bounds only see accepted samples; a dropped capture only raises overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
            xMax_q     <= X_MAX_RST;
            xMin_q     <= X_MIN_RST;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (push) begin
                if (bus.x > xMax_q) begin
                    xMax_q <= bus.x;
                end
                if (bus.x < xMin_q) begin
                    xMin_q <= bus.x;
                end
            end
        end
    end

    assign bus.out_valid = ~empty;
    assign bus.out_z     = headData[W-1:XW];
    assign bus.out_x     = headData[XW-1:0];
    assign overflow      = overflow_q;
    assign x_max         = xMax_q;
    assign x_min         = xMin_q;

endmodule
